// File: rtl/fp_sub_seq.sv
`default_nettype none
// ============================================================================
// Module   : fp_sub_seq
// Brief    : Sequential IEEE-754 single subtractor, result = A - B, with a
//            valid/ready handshake and one-bit-per-cycle normalization.
//            Define FP_SUB_GUARD_EN for guard/round/sticky and RNE rounding.
// Revision : 1.0  initial release
// ============================================================================
module fp_sub_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        busy
);

`ifdef FP_SUB_GUARD_EN
    localparam int C_GRD = 3;
`else
    localparam int C_GRD = 0;
`endif
    localparam int C_MW = 24 + C_GRD;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_SUB   = 3'd2,
        S_NORM  = 3'd3,
        S_PACK  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

`ifdef FP_SUB_GUARD_EN
    localparam state_t C_AFTER_NORM = S_PACK;
`else
    localparam state_t C_AFTER_NORM = S_DONE;
`endif

    state_t          state_q;
    logic [31:0]     a_q, b_q;
    logic            sign_q, eff_sub_q, fin_q, out_valid_q;
    logic [8:0]      exp_q;
    logic [C_MW-1:0] lm_q, sm_q;
    logic [31:0]     result_q;

    // Operand ordering and alignment, evaluated while in ALIGN.
    logic [30:0]     w_a_key, w_b_key;
    logic [31:0]     w_l, w_s;
    logic [7:0]      w_diff;
    logic [C_MW-1:0] w_lm, w_sm_full, w_sm_al;
`ifdef FP_SUB_GUARD_EN
    logic [2*C_MW-1:0] w_wide;
`endif

    always_comb begin
        w_a_key   = (a_q[30:23] == 8'd0) ? 31'd0 : a_q[30:0];
        w_b_key   = (b_q[30:23] == 8'd0) ? 31'd0 : b_q[30:0];
        w_l       = (w_a_key >= w_b_key) ? a_q : b_q;
        w_s       = (w_a_key >= w_b_key) ? b_q : a_q;
        w_diff    = w_l[30:23] - w_s[30:23];
        w_lm      = (w_l[30:23] == 8'd0) ? '0 : (C_MW'({1'b1, w_l[22:0]}) << C_GRD);
        w_sm_full = (w_s[30:23] == 8'd0) ? '0 : (C_MW'({1'b1, w_s[22:0]}) << C_GRD);
`ifdef FP_SUB_GUARD_EN
        // Everything shifted past the datapath collapses into the sticky bit.
        w_wide  = {w_sm_full, {C_MW{1'b0}}} >> w_diff;
        w_sm_al = w_wide[2*C_MW-1:C_MW] | {{(C_MW-1){1'b0}}, |w_wide[C_MW-1:0]};
        if (w_diff >= 8'd27) begin
            w_sm_al = {{(C_MW-1){1'b0}}, |w_sm_full};
        end
`else
        w_sm_al = w_sm_full >> w_diff;
`endif
    end

    logic [C_MW:0]   w_sum;
    logic [C_MW-1:0] w_carry_m;
    logic [8:0]      w_exp_inc;

    always_comb begin
        w_sum     = eff_sub_q ? ({1'b0, lm_q} - {1'b0, sm_q}) : ({1'b0, lm_q} + {1'b0, sm_q});
        w_carry_m = w_sum[C_MW:1];
`ifdef FP_SUB_GUARD_EN
        w_carry_m[0] = w_sum[1] | w_sum[0];
`endif
        w_exp_inc = exp_q + 9'd1;
    end

`ifdef FP_SUB_GUARD_EN
    logic        w_up;
    logic [24:0] w_rnd;
    always_comb begin
        w_up  = lm_q[2] & (lm_q[1] | lm_q[0] | lm_q[3]);
        w_rnd = {1'b0, lm_q[26:3]} + {24'd0, w_up};
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sign_q      <= 1'b0;
            eff_sub_q   <= 1'b0;
            fin_q       <= 1'b0;
            exp_q       <= '0;
            lm_q        <= '0;
            sm_q        <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q     <= A;
                        b_q     <= {~B[31], B[30:0]};
                        fin_q   <= 1'b0;
                        state_q <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    sign_q    <= w_l[31];
                    eff_sub_q <= w_l[31] ^ w_s[31];
                    exp_q     <= {1'b0, w_l[30:23]};
                    lm_q      <= w_lm;
                    sm_q      <= w_sm_al;
                    state_q   <= S_SUB;
                end
                S_SUB: begin
                    // Short-cut results still pass through NORM to keep latency uniform.
                    state_q <= S_NORM;
                    if (w_sum == '0) begin
                        result_q <= 32'd0;
                        fin_q    <= 1'b1;
                    end else if (w_sum[C_MW]) begin
                        if (w_exp_inc >= 9'd255) begin
                            result_q <= {sign_q, 8'hFF, 23'd0};
                            fin_q    <= 1'b1;
                        end else begin
                            lm_q  <= w_carry_m;
                            exp_q <= w_exp_inc;
                        end
                    end else begin
                        lm_q <= w_sum[C_MW-1:0];
                    end
                end
                S_NORM: begin
                    if (fin_q) begin
                        state_q     <= C_AFTER_NORM;
                        out_valid_q <= (C_AFTER_NORM == S_DONE);
                    end else if (lm_q[C_MW-1]) begin
                        result_q    <= {sign_q, exp_q[7:0], lm_q[C_MW-2 -: 23]};
                        state_q     <= C_AFTER_NORM;
                        out_valid_q <= (C_AFTER_NORM == S_DONE);
                    end else if (exp_q <= 9'd1) begin
                        result_q    <= {sign_q, 31'd0};
                        fin_q       <= 1'b1;
                        state_q     <= C_AFTER_NORM;
                        out_valid_q <= (C_AFTER_NORM == S_DONE);
                    end else begin
                        lm_q  <= lm_q << 1;
                        exp_q <= exp_q - 9'd1;
                    end
                end
`ifdef FP_SUB_GUARD_EN
                S_PACK: begin
                    if (!fin_q) begin
                        if (w_rnd[24]) begin
                            if (w_exp_inc >= 9'd255) begin
                                result_q <= {sign_q, 8'hFF, 23'd0};
                            end else begin
                                result_q <= {sign_q, w_exp_inc[7:0], 23'd0};
                            end
                        end else begin
                            result_q <= {sign_q, exp_q[7:0], w_rnd[22:0]};
                        end
                    end
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
`endif
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule
`default_nettype wire
